// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency RAM between
// instruction fetch (IF) and load/store (MEM); MEM has fixed priority.
// Ports: clk, rst (async, active high)
//        if_req/if_addr -> if_rdata/if_ready      fetch requester
//        mem_req/we/addr/wdata -> mem_rdata/ready data requester
//        ram_en/we/addr/wdata, ram_rdata          RAM side
//        stall_pipeline                           request still waiting
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_pipeline
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(RAM_LAT - 1);
   localparam logic             G_FETCH = 1'b0;
   localparam logic             G_DATA  = 1'b1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               grant_q, grant_d;
   logic               we_q, we_d;

   logic               ram_en_d, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_d;
   logic [DATA_W-1:0]  ram_wdata_d;
   logic [DATA_W-1:0]  if_rdata_d, mem_rdata_d;
   logic               if_ready_d, mem_ready_d;

   assign stall_pipeline = (if_req & ~if_ready) | (mem_req & ~mem_ready);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      we_d        = we_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      if_rdata_d  = if_rdata;
      mem_rdata_d = mem_rdata;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The RAM strobe is registered, so the latched request
            // is loaded straight into the ram_* registers here.
            if (mem_req) begin
               grant_d     = G_DATA;
               we_d        = mem_we;
               ram_en_d    = 1'b1;
               ram_we_d    = mem_we;
               ram_addr_d  = mem_addr;
               ram_wdata_d = mem_wdata;
               state_d     = ISSUE;
            end else if (if_req) begin
               grant_d     = G_FETCH;
               we_d        = 1'b0;
               ram_en_d    = 1'b1;
               ram_addr_d  = if_addr;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
         end
         WAIT: begin
            // cnt_q == 0 marks the cycle ram_rdata becomes valid.
            if (cnt_q == '0) begin
               state_d = DONE;
               if (grant_q == G_DATA) begin
                  mem_ready_d = 1'b1;
                  if (!we_q) mem_rdata_d = ram_rdata;
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         grant_q   <= G_FETCH;
         we_q      <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         we_q      <= we_d;
         ram_en    <= ram_en_d;
         ram_we    <= ram_we_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         if_rdata  <= if_rdata_d;
         mem_rdata <= mem_rdata_d;
         if_ready  <= if_ready_d;
         mem_ready <= mem_ready_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter
// against a transaction-level model, for RAM latencies 1 and 4.
module tb_mem_port_arbiter;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [15:0] if_addr = '0, mem_addr = '0;
   logic [31:0] mem_wdata = '0, ram_rdata = '0;
   logic [31:0] if_rdata, mem_rdata, ram_wdata;
   logic        if_ready, mem_ready, ram_en, ram_we, stall;
   logic [15:0] ram_addr;

   logic        if_req4 = 1'b0, mem_req4 = 1'b0, mem_we4 = 1'b0;
   logic [15:0] if_addr4 = '0, mem_addr4 = '0;
   logic [31:0] mem_wdata4 = '0, ram_rdata4 = '0;
   logic [31:0] if_rdata4, mem_rdata4, ram_wdata4;
   logic        if_ready4, mem_ready4, ram_en4, ram_we4, stall4;
   logic [15:0] ram_addr4;

   mem_port_arbiter #(.RAM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_pipeline(stall)
   );

   mem_port_arbiter #(.RAM_LAT(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .if_req(if_req4), .if_addr(if_addr4),
      .if_rdata(if_rdata4), .if_ready(if_ready4),
      .mem_req(mem_req4), .mem_we(mem_we4),
      .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
      .mem_rdata(mem_rdata4), .mem_ready(mem_ready4),
      .ram_en(ram_en4), .ram_we(ram_we4),
      .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
      .ram_rdata(ram_rdata4), .stall_pipeline(stall4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RAM device models: data valid exactly L cycles after ram_en,
   // random garbage in every other cycle.
   logic [31:0] ram [0:255];
   logic        eh1 [0:15];
   logic        eh4 [0:15];
   logic [15:0] ah1 [0:15];
   logic [15:0] ah4 [0:15];

   always @(posedge clk) begin
      #1;
      for (int i = 15; i > 0; i--) begin
         eh1[i] = eh1[i-1];
         ah1[i] = ah1[i-1];
         eh4[i] = eh4[i-1];
         ah4[i] = ah4[i-1];
      end
      eh1[0] = ram_en;
      ah1[0] = ram_addr;
      eh4[0] = ram_en4;
      ah4[0] = ram_addr4;
      if (ram_en && ram_we) ram[ram_addr[7:0]] = ram_wdata;
      ram_rdata  = eh1[LAT] ? ram[ah1[LAT][7:0]] : $urandom;
      ram_rdata4 = eh4[4] ? (32'hC0DE0000 | 32'(ah4[4])) : $urandom;
   end

   // Transaction-level reference: an accepted request produces its
   // strobe one cycle later and its ready LAT+2 cycles later; the
   // arbiter samples again LAT+3 cycles after acceptance.
   logic [31:0] ref_mem [0:255];
   int          en_cyc = -1, rdy_cyc = -1, free_cyc = 0;
   logic        p_data = 1'b0, p_we = 1'b0;
   logic [15:0] p_addr = '0;
   logic [31:0] p_wdata = '0, exp_if_rd = '0, exp_mem_rd = '0;

   always @(negedge clk) begin
      chk1("stall", stall, (if_req & ~if_ready) | (mem_req & ~mem_ready));
      if (rst) begin
         chk1("rst_en", ram_en, 1'b0);
         chk1("rst_we", ram_we, 1'b0);
         chk1("rst_irdy", if_ready, 1'b0);
         chk1("rst_mrdy", mem_ready, 1'b0);
         chk("rst_addr", 32'(ram_addr), 32'h0);
         chk("rst_wdata", ram_wdata, 32'h0);
         chk("rst_ird", if_rdata, 32'h0);
         chk("rst_mrd", mem_rdata, 32'h0);
         en_cyc     = -1;
         rdy_cyc    = -1;
         exp_if_rd  = '0;
         exp_mem_rd = '0;
         free_cyc   = cyc + 1;
      end else begin
         chk1("m_en", ram_en, cyc == en_cyc);
         if (cyc == en_cyc) begin
            chk1("m_we", ram_we, p_we);
            chk("m_addr", 32'(ram_addr), 32'(p_addr));
            if (p_we) chk("m_wdata", ram_wdata, p_wdata);
         end else begin
            chk1("m_we_idle", ram_we, 1'b0);
         end
         if (cyc == rdy_cyc) begin
            if (p_we) ref_mem[p_addr[7:0]] = p_wdata;
            else if (p_data) exp_mem_rd = ref_mem[p_addr[7:0]];
            else exp_if_rd = ref_mem[p_addr[7:0]];
         end
         chk1("m_irdy", if_ready, (cyc == rdy_cyc) && !p_data);
         chk1("m_mrdy", mem_ready, (cyc == rdy_cyc) && p_data);
         chk("m_ird", if_rdata, exp_if_rd);
         chk("m_mrd", mem_rdata, exp_mem_rd);
         if (cyc >= free_cyc && (mem_req || if_req)) begin
            p_data   = mem_req;
            p_we     = mem_req & mem_we;
            p_addr   = mem_req ? mem_addr : if_addr;
            p_wdata  = mem_wdata;
            en_cyc   = cyc + 1;
            rdy_cyc  = cyc + LAT + 2;
            free_cyc = cyc + LAT + 3;
         end
      end
   end

   logic ir, mr;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 32'h5A5A0000 | 32'(i);
         ref_mem[i] = 32'h5A5A0000 | 32'(i);
      end
      ram[8'h10]     = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) begin
         eh1[i] = 1'b0;
         eh4[i] = 1'b0;
         ah1[i] = '0;
         ah4[i] = '0;
      end

      // 1: reset held with requests active
      if_req   = 1'b1;
      if_addr  = 16'h0010;
      mem_req  = 1'b1;
      mem_addr = 16'h0100;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk1("t1_en", ram_en, 1'b0);
         chk1("t1_irdy", if_ready, 1'b0);
         chk1("t1_stall", stall, 1'b1);
         chk("t1_mrd", mem_rdata, 32'h0);
      end
      tick();
      rst     = 1'b0;
      if_req  = 1'b0;
      mem_req = 1'b0;
      tick();

      // 2: single fetch, LAT=1
      tick();
      if_req  = 1'b1;
      if_addr = 16'h0010;
      @(negedge clk);
      chk1("t2_stall0", stall, 1'b1);
      chk1("t2_en0", ram_en, 1'b0);
      tick();
      @(negedge clk);
      chk1("t2_en1", ram_en, 1'b1);
      chk1("t2_we1", ram_we, 1'b0);
      chk("t2_addr1", 32'(ram_addr), 32'h0010);
      chk1("t2_stall1", stall, 1'b1);
      tick();
      @(negedge clk);
      chk1("t2_en2", ram_en, 1'b0);
      chk1("t2_stall2", stall, 1'b1);
      tick();
      @(negedge clk);
      chk1("t2_rdy3", if_ready, 1'b1);
      chk("t2_rd3", if_rdata, 32'hDEADBEEF);
      chk1("t2_stall3", stall, 1'b0);
      tick();
      if_req = 1'b0;
      @(negedge clk);
      chk1("t2_rdy4", if_ready, 1'b0);
      tick();

      // 3: simultaneous requests, MEM wins
      tick();
      if_req   = 1'b1;
      if_addr  = 16'h0010;
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 16'h0100;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk1("t3_mrdy", mem_ready, c == 3);
         chk1("t3_irdy", if_ready, c == 7);
         chk1("t3_en", ram_en, (c == 1) || (c == 5));
         if (c == 3) chk("t3_mrd", mem_rdata, 32'h5A5A0000);
         tick();
         if (c == 3) mem_req = 1'b0;
         if (c == 7) if_req = 1'b0;
      end

      // 4: store leaves mem_rdata alone
      tick();
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 16'h0020;
      mem_wdata = 32'h12345678;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk1("t4_en", ram_en, c == 1);
         chk1("t4_we", ram_we, c == 1);
         if (c == 1) begin
            chk("t4_addr", 32'(ram_addr), 32'h0020);
            chk("t4_wdata", ram_wdata, 32'h12345678);
         end
         chk1("t4_mrdy", mem_ready, c == 3);
         chk("t4_mrd", mem_rdata, 32'h5A5A0000);
         tick();
         if (c == 3) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
         end
      end

      // 5: reset in cycle 2 of a fetch
      tick();
      if_req  = 1'b1;
      if_addr = 16'h0030;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk1("t5_en1", ram_en, 1'b1);
      tick();
      rst    = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      chk1("t5_en2", ram_en, 1'b0);
      chk1("t5_rdy2", if_ready, 1'b0);
      tick();
      rst = 1'b0;
      for (int c = 3; c < 8; c++) begin
         @(negedge clk);
         chk1("t5_norst_rdy", if_ready, 1'b0);
         chk1("t5_norst_en", ram_en, 1'b0);
         tick();
      end
      if_req  = 1'b1;
      if_addr = 16'h0030;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk1("t5_rdy", if_ready, c == 3);
         if (c == 3) chk("t5_rd", if_rdata, 32'h5A5A0030);
         tick();
      end
      if_req = 1'b0;
      tick();

      // 6: load with RAM_LAT=4
      tick();
      mem_req4  = 1'b1;
      mem_we4   = 1'b0;
      mem_addr4 = 16'h0044;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk1("t6_en", ram_en4, c == 1);
         chk1("t6_we", ram_we4, 1'b0);
         chk1("t6_mrdy", mem_ready4, c == 6);
         chk1("t6_stall", stall4, c < 6);
         chk("t6_mrd", mem_rdata4, (c >= 6) ? 32'hC0DE0044 : 32'h0);
         tick();
         if (c == 6) mem_req4 = 1'b0;
      end

      // random traffic, both requesters
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         ir = if_ready;
         mr = mem_ready;
         tick();
         if (mem_req) begin
            if (mr) mem_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            mem_req   = 1'b1;
            mem_we    = 1'($urandom_range(0, 1));
            mem_addr  = 16'($urandom_range(0, 31));
            mem_wdata = $urandom;
         end
         if (if_req) begin
            if (ir) if_req = 1'b0;
         end else if ($urandom_range(0, 1) == 0) begin
            if_req  = 1'b1;
            if_addr = 16'($urandom_range(0, 31));
         end
      end
      if_req  = 1'b0;
      mem_req = 1'b0;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
